t_bank_ctrl: RTL and testbench
==============================

Name: t_bank_ctrl

Overview:
- Sequencer for a bank of WIDTH T flip-flops. Each flip-flop has ports clk, t, rst and q.
- The block drives the bank's toggle vector so the bank counts modulo LIMIT+1, up or down, in continuous or one-shot mode.
- It also provides a synchronous clear (toggle-to-zero), a run/stop control FSM, and a saturating wrap counter.
- It sits beside the flip-flop bank. Its q_vec input comes from the bank outputs, and its t_vec output goes to the bank t inputs.

Parameters:
- WIDTH, 4, number of T flip-flops in the bank (2..16).
- WRAP_W, 8, width of the wrap counter.

Ports:
- clk  in  1  system clock; rising edge; shared with the bank.
- rst  in  1  asynchronous, active-high reset; shared with the bank, which resets q to 0.
- start  in  1  level; begin or resume counting.
- stop  in  1  level; halt counting, bank holds its value.
- clear  in  1  level; return bank to 0 and clear wrap_cnt.
- dir  in  1  1 = up, 0 = down; sampled every cycle.
- oneshot  in  1  1 = stop after first wrap; sampled every cycle.
- limit  in  WIDTH  terminal value; count range is 0..limit.
- q_vec  in  WIDTH  current bank outputs.
- t_vec  out  WIDTH  toggle enables to the bank; combinational from state, dir, limit and q_vec.
- busy  out  1  1 while in RUN.
- done  out  1  one-shot completion flag.
- tc  out  1  terminal-count indicator; combinational.
- wrap_cnt  out  WRAP_W  number of wraps since the last clear or reset; saturating.

Behaviour:
- Reset, asynchronous on rst=1: state=IDLE, done=0, wrap_cnt=0, busy=0, t_vec=0.
- States are IDLE, RUN, CLEAR and DONE. All outputs other than t_vec and tc are registered.
- Command priority when inputs are simultaneous: clear > stop > start.
- IDLE:
  - t_vec=0.
  - clear -> CLEAR.
  - start -> RUN.
- RUN:
  - busy=1.
  - clear -> CLEAR.
  - stop -> IDLE; bank holds its value.
  - On a wrap cycle with oneshot=1 -> DONE. The wrap toggle is still applied that cycle.
  - Otherwise stay in RUN.
- CLEAR:
  - Lasts exactly 1 cycle, with t_vec=q_vec so the bank reads 0 after the edge.
  - wrap_cnt<=0 and done<=0.
  - Next state is IDLE, even if clear is still high. If clear is still high, IDLE re-enters CLEAR, which is harmless because q is already 0.
- DONE:
  - done=1, t_vec=0.
  - start -> RUN, and done<=0 on the same edge.
  - clear -> CLEAR.
  - stop is ignored.
- Toggle generation in RUN, up mode (dir=1):
  - tc = (q_vec >= limit).
  - If tc: t_vec=q_vec, so the bank goes to 0. This is a wrap.
  - Else: t_vec[0]=1 and t_vec[i]=&q_vec[i-1:0], which is a binary increment.
- Toggle generation in RUN, down mode (dir=0):
  - tc = (q_vec == 0).
  - If tc: t_vec=limit, so the bank loads limit. This is a wrap.
  - Else: t_vec[0]=1 and t_vec[i]=&(~q_vec[i-1:0]), which is a binary decrement.
- Latency: the bank value changes on the clk edge that follows the cycle in which t_vec is asserted. The first count occurs on the edge after RUN is entered.
- Limit edge cases:
  - limit=0: up mode wraps every cycle and q stays 0; down mode also holds 0. Each such cycle counts as a wrap.
  - limit changed mid-run: up mode with q>limit wraps to 0 on the next edge; down mode keeps decrementing normally.
  - dir changed mid-run: takes effect in the same cycle, with no extra state.
- wrap_cnt increments by 1 on each wrap edge in RUN and saturates at 2^WRAP_W-1.
- tc is 0 outside RUN.
- Reset asserted mid-RUN: everything returns to reset values immediately, with no dependence on the clock.

Test Plan:
- WIDTH=4, limit=9, dir=1, oneshot=0, pulse start -> q sequence 1,2,...,9,0,1 on successive edges; tc=1 while q=9; wrap_cnt=1 after q returns to 0.
- limit=9, dir=0, start from q=0 -> first edge gives q=9, tc=1 in the preceding cycle; then 8,7,...,0,9; wrap_cnt increments on each 0->9 edge.
- oneshot=1, limit=3, up, from 0 -> q=1,2,3,0, then state=DONE, done=1, busy=0; q stays 0 for 10 cycles; a start pulse clears done and counting resumes.
- Run up to q=6, assert stop+start together -> IDLE, q holds 6, t_vec=0; start alone later -> next edges give q=7,8.
- q=5 with wrap_cnt=2, assert clear+stop+start together -> one CLEAR cycle with t_vec=5, then q=0, wrap_cnt=0, state=IDLE.
- Running with limit=12 and q=11, change limit to 7 -> next edge gives q=0 and wrap_cnt+1; then raise rst asynchronously between edges -> q=0, state=IDLE, done=0, wrap_cnt=0 immediately. Additionally, saturation with WRAP_W=2, limit=0 up -> wrap_cnt goes 1,2,3,3.

Source files
------------

// File: rtl/t_bank_ctrl_if.sv
// Command, status and bank-side vectors shared between the T flip-flop bank
// sequencer and whoever drives it.
interface t_bank_ctrl_if #(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 8
);
    logic              start;
    logic              stop;
    logic              clear;
    logic              dir;
    logic              oneshot;
    logic [WIDTH-1:0]  limit;
    logic [WIDTH-1:0]  q_vec;
    logic [WIDTH-1:0]  t_vec;
    logic              busy;
    logic              done;
    logic              tc;
    logic [WRAP_W-1:0] wrap_cnt;

    modport master (
        output start, stop, clear, dir, oneshot, limit, q_vec,
        input  t_vec, busy, done, tc, wrap_cnt
    );

    modport slave (
        input  start, stop, clear, dir, oneshot, limit, q_vec,
        output t_vec, busy, done, tc, wrap_cnt
    );
endinterface

// File: rtl/t_bank_ctrl.sv
// Sequencer for a bank of T flip-flops: up/down modulo-(limit+1) counting,
// one-shot stop, toggle-to-zero clear and a saturating wrap counter.
module t_bank_ctrl #(
    parameter int WIDTH  = 4,
    parameter int WRAP_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    t_bank_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        CLEAR = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            next_s;
    logic [WIDTH-1:0]  inc_mask_s;
    logic [WIDTH-1:0]  dec_mask_s;
    logic [WIDTH-1:0]  t_s;
    logic              tc_s;
    logic              wrap_s;
    logic              busy_r;
    logic              done_r;
    logic [WRAP_W-1:0] wrap_cnt_r;

    function automatic logic [WRAP_W-1:0] sat_inc(input logic [WRAP_W-1:0] v);
        if (v == {WRAP_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + WRAP_W'(1'b1);
        end
    endfunction

    // Bit i toggles on increment when all lower bits are 1, on decrement when all are 0
    assign inc_mask_s[0] = 1'b1;
    assign dec_mask_s[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_mask
        assign inc_mask_s[i] = &bus.q_vec[i-1:0];
        assign dec_mask_s[i] = ~|bus.q_vec[i-1:0];
    end

    // Next-state, toggle vector and terminal-count decode
    always_comb begin
        next_s = state_r;
        t_s    = {WIDTH{1'b0}};
        tc_s   = 1'b0;
        wrap_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.clear) begin
                    next_s = CLEAR;
                end else if (bus.start) begin
                    next_s = RUN;
                end else begin
                    next_s = IDLE;
                end
            end
            RUN: begin
                tc_s = bus.dir ? (bus.q_vec >= bus.limit) : (bus.q_vec == {WIDTH{1'b0}});
                if (bus.clear) begin
                    next_s = CLEAR;
                end else if (bus.stop) begin
                    next_s = IDLE;
                end else begin
                    // A wrap toggles q back to 0 (up) or loads limit from 0 (down)
                    wrap_s = tc_s;
                    if (tc_s) begin
                        t_s = bus.dir ? bus.q_vec : bus.limit;
                    end else begin
                        t_s = bus.dir ? inc_mask_s : dec_mask_s;
                    end
                    if (tc_s && bus.oneshot) begin
                        next_s = DONE;
                    end else begin
                        next_s = RUN;
                    end
                end
            end
            CLEAR: begin
                t_s    = bus.q_vec;
                next_s = IDLE;
            end
            DONE: begin
                if (bus.clear) begin
                    next_s = CLEAR;
                end else if (bus.start) begin
                    next_s = RUN;
                end else begin
                    next_s = DONE;
                end
            end
            default: begin
                next_s = IDLE;
            end
        endcase
    end

    // State and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            wrap_cnt_r <= {WRAP_W{1'b0}};
        end else begin
            state_r <= next_s;
            busy_r  <= (next_s == RUN);
            done_r  <= (next_s == DONE);
            if (state_r == CLEAR) begin
                wrap_cnt_r <= {WRAP_W{1'b0}};
            end else if (wrap_s) begin
                wrap_cnt_r <= sat_inc(wrap_cnt_r);
            end else begin
                wrap_cnt_r <= wrap_cnt_r;
            end
        end
    end

    assign bus.t_vec    = t_s;
    assign bus.tc       = tc_s;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.wrap_cnt = wrap_cnt_r;
endmodule

// File: tb/tb_t_bank_ctrl.sv
// Self-checking bench for t_bank_ctrl: models the T flip-flop bank and compares
// bank values, tc and status against a queue of expected results.
module tb_t_bank_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_pass = 0;

    typedef struct {
        logic [3:0] q;
        logic       tc;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] sat_q[$];

    t_bank_ctrl_if #(.WIDTH(4), .WRAP_W(8)) bus ();
    t_bank_ctrl_if #(.WIDTH(4), .WRAP_W(2)) s_bus ();

    t_bank_ctrl #(.WIDTH(4), .WRAP_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
    t_bank_ctrl #(.WIDTH(4), .WRAP_W(2)) dut_sat (.clk(clk), .rst(rst), .bus(s_bus));

    always #5 clk = ~clk;

    // T flip-flop banks: q toggles where t is set, reset to 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.q_vec   <= 4'd0;
            s_bus.q_vec <= 4'd0;
        end else begin
            bus.q_vec   <= bus.q_vec ^ bus.t_vec;
            s_bus.q_vec <= s_bus.q_vec ^ s_bus.t_vec;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected modulo-(lim+1) up count starting from 'from'
    task automatic push_up(input int from, input int n, input int lim);
        int   cur = from;
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.tc = (cur >= lim);
            cur  = e.tc ? 0 : cur + 1;
            e.q  = 4'(cur);
            exp_q.push_back(e);
        end
    endtask

    task automatic push_down(input int from, input int n, input int lim);
        int   cur = from;
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.tc = (cur == 0);
            cur  = e.tc ? lim : cur - 1;
            e.q  = 4'(cur);
            exp_q.push_back(e);
        end
    endtask

    task automatic start_pulse();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        n_checks++; if (bus.q_vec !== 4'd0) $display("FAIL reset_q got %0d want 0", bus.q_vec); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.done !== 1'b0) $display("FAIL reset_done got %b want 0", bus.done); else n_pass++;
        n_checks++; if (bus.wrap_cnt !== 8'd0) $display("FAIL reset_wrap got %0d want 0", bus.wrap_cnt); else n_pass++;
        n_checks++; if (bus.t_vec !== 4'd0) $display("FAIL reset_tvec got %0d want 0", bus.t_vec); else n_pass++;
        n_checks++; if (s_bus.wrap_cnt !== 2'd0) $display("FAIL reset_sat_wrap got %0d want 0", s_bus.wrap_cnt); else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++; if (bus.tc !== 1'b0) $display("FAIL idle_tc got %b want 0", bus.tc); else n_pass++;
    endtask

    task automatic test_up_count();
        exp_t e;
        bus.limit = 4'd9; bus.dir = 1'b1; bus.oneshot = 1'b0;
        start_pulse();
        push_up(0, 11, 9);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++; if (bus.tc !== e.tc) $display("FAIL up_tc got %b want %b", bus.tc, e.tc); else n_pass++;
            tick();
            n_checks++; if (bus.q_vec !== e.q) $display("FAIL up_q got %0d want %0d", bus.q_vec, e.q); else n_pass++;
        end
        n_checks++; if (bus.wrap_cnt !== 8'd1) $display("FAIL up_wrap got %0d want 1", bus.wrap_cnt); else n_pass++;
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL up_busy got %b want 1", bus.busy); else n_pass++;
        do_clear();
    endtask

    task automatic test_down_count();
        exp_t e;
        bus.limit = 4'd9; bus.dir = 1'b0; bus.oneshot = 1'b0;
        start_pulse();
        push_down(0, 11, 9);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++; if (bus.tc !== e.tc) $display("FAIL down_tc got %b want %b", bus.tc, e.tc); else n_pass++;
            tick();
            n_checks++; if (bus.q_vec !== e.q) $display("FAIL down_q got %0d want %0d", bus.q_vec, e.q); else n_pass++;
        end
        n_checks++; if (bus.wrap_cnt !== 8'd2) $display("FAIL down_wrap got %0d want 2", bus.wrap_cnt); else n_pass++;
        do_clear();
        n_checks++; if (bus.wrap_cnt !== 8'd0) $display("FAIL clear_wrap got %0d want 0", bus.wrap_cnt); else n_pass++;
    endtask

    task automatic test_oneshot();
        exp_t e;
        bus.limit = 4'd3; bus.dir = 1'b1; bus.oneshot = 1'b1;
        start_pulse();
        push_up(0, 4, 3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++; if (bus.tc !== e.tc) $display("FAIL os_tc got %b want %b", bus.tc, e.tc); else n_pass++;
            tick();
            n_checks++; if (bus.q_vec !== e.q) $display("FAIL os_q got %0d want %0d", bus.q_vec, e.q); else n_pass++;
        end
        n_checks++; if (bus.done !== 1'b1) $display("FAIL os_done got %b want 1", bus.done); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL os_busy got %b want 0", bus.busy); else n_pass++;
        bus.stop = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            n_checks++; if (bus.q_vec !== 4'd0 || bus.done !== 1'b1) $display("FAIL os_hold got q=%0d done=%b want q=0 done=1", bus.q_vec, bus.done); else n_pass++;
        end
        bus.stop = 1'b0; bus.oneshot = 1'b0;
        start_pulse();
        n_checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b1) $display("FAIL os_restart got done=%b busy=%b want 0 1", bus.done, bus.busy); else n_pass++;
        push_up(0, 2, 3);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tick();
            n_checks++; if (bus.q_vec !== e.q) $display("FAIL os_resume_q got %0d want %0d", bus.q_vec, e.q); else n_pass++;
        end
        do_clear();
    endtask

    task automatic test_stop_hold();
        exp_t e;
        bus.limit = 4'd9; bus.dir = 1'b1; bus.oneshot = 1'b0;
        start_pulse();
        push_up(0, 6, 9);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tick();
            n_checks++; if (bus.q_vec !== e.q) $display("FAIL stop_run_q got %0d want %0d", bus.q_vec, e.q); else n_pass++;
        end
        bus.stop = 1'b1; bus.start = 1'b1;
        #1;
        n_checks++; if (bus.t_vec !== 4'd0) $display("FAIL stop_tvec got %0d want 0", bus.t_vec); else n_pass++;
        tick();
        bus.stop = 1'b0; bus.start = 1'b0;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL stop_busy got %b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.t_vec !== 4'd0) $display("FAIL stop_idle_tvec got %0d want 0", bus.t_vec); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            e.q = 4'd6; e.tc = 1'b0;
            exp_q.push_back(e);
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++; if (bus.q_vec !== e.q) $display("FAIL stop_hold_q got %0d want %0d", bus.q_vec, e.q); else n_pass++;
            tick();
        end
        start_pulse();
        push_up(6, 2, 9);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tick();
            n_checks++; if (bus.q_vec !== e.q) $display("FAIL stop_resume_q got %0d want %0d", bus.q_vec, e.q); else n_pass++;
        end
        do_clear();
    endtask

    task automatic test_clear_priority();
        exp_t e;
        bus.limit = 4'd5; bus.dir = 1'b0; bus.oneshot = 1'b0;
        start_pulse();
        push_down(0, 7, 5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tick();
            n_checks++; if (bus.q_vec !== e.q) $display("FAIL clr_setup_q got %0d want %0d", bus.q_vec, e.q); else n_pass++;
        end
        n_checks++; if (bus.wrap_cnt !== 8'd2) $display("FAIL clr_setup_wrap got %0d want 2", bus.wrap_cnt); else n_pass++;
        bus.clear = 1'b1; bus.stop = 1'b1; bus.start = 1'b1;
        tick();
        bus.clear = 1'b0; bus.stop = 1'b0; bus.start = 1'b0;
        n_checks++; if (bus.t_vec !== 4'd5) $display("FAIL clr_tvec got %0d want 5", bus.t_vec); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL clr_busy got %b want 0", bus.busy); else n_pass++;
        tick();
        n_checks++; if (bus.q_vec !== 4'd0) $display("FAIL clr_q got %0d want 0", bus.q_vec); else n_pass++;
        n_checks++; if (bus.wrap_cnt !== 8'd0) $display("FAIL clr_wrap got %0d want 0", bus.wrap_cnt); else n_pass++;
        n_checks++; if (bus.t_vec !== 4'd0 || bus.busy !== 1'b0) $display("FAIL clr_idle got t=%0d busy=%b want 0 0", bus.t_vec, bus.busy); else n_pass++;
    endtask

    task automatic test_limit_change_reset();
        exp_t e;
        bus.limit = 4'd12; bus.dir = 1'b1; bus.oneshot = 1'b0;
        start_pulse();
        push_up(0, 11, 12);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tick();
            n_checks++; if (bus.q_vec !== e.q) $display("FAIL lim_run_q got %0d want %0d", bus.q_vec, e.q); else n_pass++;
        end
        bus.limit = 4'd7;
        #1;
        n_checks++; if (bus.tc !== 1'b1) $display("FAIL lim_tc got %b want 1", bus.tc); else n_pass++;
        tick();
        n_checks++; if (bus.q_vec !== 4'd0) $display("FAIL lim_wrap_q got %0d want 0", bus.q_vec); else n_pass++;
        n_checks++; if (bus.wrap_cnt !== 8'd1) $display("FAIL lim_wrap_cnt got %0d want 1", bus.wrap_cnt); else n_pass++;
        push_up(0, 2, 7);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            tick();
            n_checks++; if (bus.q_vec !== e.q) $display("FAIL lim_after_q got %0d want %0d", bus.q_vec, e.q); else n_pass++;
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.q_vec !== 4'd0) $display("FAIL arst_q got %0d want 0", bus.q_vec); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) $display("FAIL arst_status got busy=%b done=%b want 0 0", bus.busy, bus.done); else n_pass++;
        n_checks++; if (bus.wrap_cnt !== 8'd0) $display("FAIL arst_wrap got %0d want 0", bus.wrap_cnt); else n_pass++;
        n_checks++; if (bus.t_vec !== 4'd0) $display("FAIL arst_tvec got %0d want 0", bus.t_vec); else n_pass++;
        tick();
        rst = 1'b0;
        repeat (2) tick();
        n_checks++; if (bus.q_vec !== 4'd0 || bus.busy !== 1'b0) $display("FAIL arst_idle got q=%0d busy=%b want 0 0", bus.q_vec, bus.busy); else n_pass++;
    endtask

    task automatic test_saturation();
        logic [1:0] w;
        s_bus.limit = 4'd0; s_bus.dir = 1'b1; s_bus.oneshot = 1'b0;
        s_bus.start = 1'b1;
        tick();
        s_bus.start = 1'b0;
        sat_q.push_back(2'd1); sat_q.push_back(2'd2);
        sat_q.push_back(2'd3); sat_q.push_back(2'd3);
        while (sat_q.size() > 0) begin
            w = sat_q.pop_front();
            n_checks++; if (s_bus.tc !== 1'b1) $display("FAIL sat_tc got %b want 1", s_bus.tc); else n_pass++;
            tick();
            n_checks++; if (s_bus.wrap_cnt !== w) $display("FAIL sat_wrap got %0d want %0d", s_bus.wrap_cnt, w); else n_pass++;
            n_checks++; if (s_bus.q_vec !== 4'd0) $display("FAIL sat_q got %0d want 0", s_bus.q_vec); else n_pass++;
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.stop = 1'b0; bus.clear = 1'b0;
        bus.dir = 1'b1; bus.oneshot = 1'b0; bus.limit = 4'd9;
        s_bus.start = 1'b0; s_bus.stop = 1'b0; s_bus.clear = 1'b0;
        s_bus.dir = 1'b1; s_bus.oneshot = 1'b0; s_bus.limit = 4'd0;
        test_reset();
        test_up_count();
        test_down_count();
        test_oneshot();
        test_stop_hold();
        test_clear_priority();
        test_limit_change_reset();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired after %0d checks", n_checks);
        $fatal(1, "watchdog");
    end
endmodule
